// File: rtl/mips_pkg.sv
// mips_pkg: constants shared across the fetch slice.
//   - opcode values for the control unit
//   - default reset PC
//   - fetch FSM state encoding
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry skid buffer for the fetch stage. Catches a memory
// response that arrives while the IF/ID register is stalled.
//   Clk, Reset        clock, async active-high reset
//   load_i            capture instr_i/pcp4_i, mark full
//   drain_i           entry consumed, mark empty
//   clear_i           discard entry (redirect); wins over load/drain
//   instr_i, pcp4_i   entry data in
//   instr_o, pcp4_o   entry data out
//   full_o            entry holds a live instruction
module fetch_skid (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcp4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcp4_o,
    output logic        full_o
);

    logic [31:0] instr_q;
    logic [31:0] pcp4_q;
    logic        full_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            full_q  <= 1'b0;
        end else if (clear_i) begin
            full_q  <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pcp4_q  <= pcp4_i;
            full_q  <= 1'b1;
        end else if (drain_i) begin
            full_q  <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pcp4_o  = pcp4_q;
    assign full_o  = full_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register and one-entry skid.
//   Clk, Reset                  clock, async active-high reset
//   Stall                       freeze IF/ID
//   BranchTaken, BranchTarget   redirect (highest priority)
//   ImemReq, ImemAddr           memory request / address (= PC)
//   ImemReady, ImemData         memory response
//   Instr, OpCode, PcPlus4      IF/ID contents
//   Valid                       IF/ID holds a live instruction
//   AlignErr                    sticky misaligned-redirect flag
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect check;
// when undefined AlignErr is 0 and BranchTarget is used unmodified).
//
// state | meaning
// FETCH | request issued at PC every cycle
// HOLD  | response parked in skid, waiting for Stall to drop; no request
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic [5:0]  OpCode,
    output logic [31:0] PcPlus4,
    output logic        Valid,
    output logic        AlignErr
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    logic        skid_load, skid_drain, skid_clear, skid_full;
    logic [31:0] skid_instr, skid_pcp4;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_pc = {BranchTarget[31:2], 2'b00};
`else
    assign redirect_pc = BranchTarget;
`endif

    // state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        if (BranchTaken) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: if (ImemReady && Stall) state_d = ST_HOLD;
                ST_HOLD:  if (!Stall)             state_d = ST_FETCH;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    // outputs; the async reset forces FETCH, so the request is masked
    // explicitly while Reset is high
    always_comb begin
        ImemReq  = (state_q == ST_FETCH) && !Reset;
        ImemAddr = pc_q;
    end

    // datapath next values
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcp4_d     = pcp4_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        if (BranchTaken) begin
            // redirect drops skid contents and any same-cycle response
            pc_d       = redirect_pc;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
        end else if (state_q == ST_FETCH) begin
            if (ImemReady) begin
                pc_d = pc_plus4;
                if (!Stall) begin
                    instr_d = ImemData;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                end else begin
                    skid_load = 1'b1;
                end
            end else if (!Stall) begin
                valid_d = 1'b0;
            end
        end else if (!Stall) begin
            instr_d    = skid_instr;
            pcp4_d     = skid_pcp4;
            valid_d    = skid_full;
            skid_drain = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    fetch_skid u_skid (
        .Clk     (Clk),
        .Reset   (Reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .instr_i (ImemData),
        .pcp4_i  (pc_plus4),
        .instr_o (skid_instr),
        .pcp4_o  (skid_pcp4),
        .full_o  (skid_full)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                                  align_q <= 1'b0;
        else if (BranchTaken && |BranchTarget[1:0]) align_q <= 1'b1;
    end

    assign AlignErr = align_q;
`else
    assign AlignErr = 1'b0;
`endif

    assign Instr   = instr_q;
    assign OpCode  = opcode_of(instr_q);
    assign PcPlus4 = pcp4_q;
    assign Valid   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import mips_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemData;
    logic [31:0] Instr;
    logic [5:0]  OpCode;
    logic [31:0] PcPlus4;
    logic        Valid;
    logic        AlignErr;

    int errors = 0;
    int checks = 0;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] ALIGN_ADDR = 32'h0000_0040;
    localparam logic        ALIGN_ERR  = 1'b1;
`else
    localparam logic [31:0] ALIGN_ADDR = 32'h0000_0042;
    localparam logic        ALIGN_ERR  = 1'b0;
`endif

    fetch_stage dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemReady    (ImemReady),
        .ImemData     (ImemData),
        .Instr        (Instr),
        .OpCode       (OpCode),
        .PcPlus4      (PcPlus4),
        .Valid        (Valid),
        .AlignErr     (AlignErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        br;
        logic [31:0] tgt;
        logic        stall;
        logic        ready;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_instr;
        logic [31:0] e_pcp4;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic br, input logic [31:0] tgt, input logic st,
                         input logic rdy, input logic [31:0] dat);
        BranchTaken  = br;
        BranchTarget = tgt;
        Stall        = st;
        ImemReady    = rdy;
        ImemData     = dat;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        //            br   tgt           st   rdy  data          req  addr          vld  chk  instr         pcp4
        vecs[0]  = '{1'b0, 32'h0,        1'b0,1'b1,32'h8C08_0004,1'b1,32'h0000_0004,1'b1,1'b1,32'h8C08_0004,32'h0000_0004};
        vecs[1]  = '{1'b0, 32'h0,        1'b0,1'b1,32'h1111_1111,1'b1,32'h0000_0008,1'b1,1'b1,32'h1111_1111,32'h0000_0008};
        vecs[2]  = '{1'b0, 32'h0,        1'b1,1'b1,32'h2222_2222,1'b0,32'h0000_000C,1'b1,1'b1,32'h1111_1111,32'h0000_0008};
        vecs[3]  = '{1'b0, 32'h0,        1'b1,1'b1,32'hDEAD_0001,1'b0,32'h0000_000C,1'b1,1'b1,32'h1111_1111,32'h0000_0008};
        vecs[4]  = '{1'b0, 32'h0,        1'b1,1'b1,32'hDEAD_0002,1'b0,32'h0000_000C,1'b1,1'b1,32'h1111_1111,32'h0000_0008};
        vecs[5]  = '{1'b0, 32'h0,        1'b0,1'b1,32'hDEAD_0003,1'b1,32'h0000_000C,1'b1,1'b1,32'h2222_2222,32'h0000_000C};
        vecs[6]  = '{1'b0, 32'h0,        1'b0,1'b0,32'hDEAD_0004,1'b1,32'h0000_000C,1'b0,1'b0,32'h0,        32'h0};
        vecs[7]  = '{1'b0, 32'h0,        1'b1,1'b0,32'hDEAD_0005,1'b1,32'h0000_000C,1'b0,1'b0,32'h0,        32'h0};
        vecs[8]  = '{1'b0, 32'h0,        1'b0,1'b1,32'h3333_3333,1'b1,32'h0000_0010,1'b1,1'b1,32'h3333_3333,32'h0000_0010};
        vecs[9]  = '{1'b1, 32'h0000_0040,1'b1,1'b1,32'h4444_4444,1'b1,32'h0000_0040,1'b0,1'b0,32'h0,        32'h0};
        vecs[10] = '{1'b0, 32'h0,        1'b1,1'b1,32'h5555_5555,1'b0,32'h0000_0044,1'b0,1'b0,32'h0,        32'h0};
        vecs[11] = '{1'b1, 32'h0000_0080,1'b1,1'b0,32'hDEAD_0006,1'b1,32'h0000_0080,1'b0,1'b0,32'h0,        32'h0};
        vecs[12] = '{1'b0, 32'h0,        1'b0,1'b0,32'hDEAD_0007,1'b1,32'h0000_0080,1'b0,1'b0,32'h0,        32'h0};
        vecs[13] = '{1'b0, 32'h0,        1'b0,1'b1,32'h6666_6666,1'b1,32'h0000_0084,1'b1,1'b1,32'h6666_6666,32'h0000_0084};
        vecs[14] = '{1'b1, 32'hFFFF_FFFC,1'b0,1'b1,32'hDEAD_BEEF,1'b1,32'hFFFF_FFFC,1'b0,1'b0,32'h0,        32'h0};
        vecs[15] = '{1'b0, 32'h0,        1'b0,1'b1,32'h7777_7777,1'b1,32'h0000_0000,1'b1,1'b1,32'h7777_7777,32'h0000_0000};
        vecs[16] = '{1'b1, 32'h0000_0042,1'b0,1'b0,32'hDEAD_0008,1'b1,ALIGN_ADDR,   1'b0,1'b0,32'h0,        32'h0};
        vecs[17] = '{1'b0, 32'h0,        1'b0,1'b1,32'h8888_8888,1'b1,ALIGN_ADDR+32'd4,1'b1,1'b1,32'h8888_8888,ALIGN_ADDR+32'd4};

        Reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk("rst_req",     {31'b0, ImemReq},  32'h0);
        chk("rst_valid",   {31'b0, Valid},    32'h0);
        chk("rst_instr",   Instr,             32'h0);
        chk("rst_pcp4",    PcPlus4,           32'h0);
        chk("rst_align",   {31'b0, AlignErr}, 32'h0);
        chk("rst_addr",    ImemAddr,          32'h0);

        Reset = 1'b0;
        #1;
        chk("rel_req",     {31'b0, ImemReq},  32'h1);
        chk("rel_addr",    ImemAddr,          32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].br, vecs[i].tgt, vecs[i].stall, vecs[i].ready, vecs[i].data);
            step();
            chk($sformatf("v%0d_req", i),   {31'b0, ImemReq}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  ImemAddr,         vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, Valid},   {31'b0, vecs[i].e_valid});
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_instr", i), Instr,   vecs[i].e_instr);
                chk($sformatf("v%0d_pcp4", i),  PcPlus4, vecs[i].e_pcp4);
            end
            if (i == 0) chk("v0_opcode", {26'b0, OpCode}, {26'b0, OP_LW});
        end

        // misaligned-redirect flag stays set across further cycles
        chk("align_flag", {31'b0, AlignErr}, {31'b0, ALIGN_ERR});
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h9999_0000);
        step();
        chk("align_sticky", {31'b0, AlignErr}, {31'b0, ALIGN_ERR});

        // park a response in the skid, then reset while in HOLD
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA_0000);
        step();
        chk("hold_req", {31'b0, ImemReq}, 32'h0);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_req",   {31'b0, ImemReq},  32'h0);
        chk("async_valid", {31'b0, Valid},    32'h0);
        chk("async_addr",  ImemAddr,          32'h0);
        chk("async_instr", Instr,             32'h0);
        chk("async_align", {31'b0, AlignErr}, 32'h0);
        step();
        Reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h9999_9999);
        #1;
        chk("rst2_addr",  ImemAddr,       32'h0);
        chk("rst2_req",   {31'b0, ImemReq}, 32'h1);
        chk("rst2_valid", {31'b0, Valid},   32'h0);
        step();
        chk("rst2_instr", Instr,            32'h9999_9999);
        chk("rst2_pcp4",  PcPlus4,          32'h0000_0004);
        chk("rst2_v",     {31'b0, Valid},   32'h1);
        chk("rst2_next",  ImemAddr,         32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Stall  input  1  downstream hold request; IF/ID contents frozen while high.
REQ-005 SHALL have port BranchTaken  input  1  redirect request, single-cycle pulse from execute.
REQ-006 SHALL have port BranchTarget  input  32  redirect PC, sampled when BranchTaken=1.
REQ-007 SHALL have port ImemReq  output  1  instruction-memory read request.
REQ-008 SHALL have port ImemAddr  output  32  fetch address (current PC).
REQ-009 SHALL have port ImemReady  input  1  memory response valid this cycle; may assert in the same cycle as ImemReq.
REQ-010 SHALL have port ImemData  input  32  instruction word, valid when ImemReady=1.
REQ-011 SHALL have port Instr  output  32  IF/ID instruction register.
REQ-012 SHALL have port OpCode  output  6  Instr[31:26], fed to the control unit.
REQ-013 SHALL have port PcPlus4  output  32  address of Instr plus 4.
REQ-014 SHALL have port Valid  output  1  Instr/PcPlus4 hold a live instruction.
REQ-015 SHALL have port AlignErr  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL implement a two-state FSM: FETCH (ImemReq=1, ImemAddr=PC) and HOLD (ImemReq=0).
REQ-017 In FETCH with ImemReady=1 and Stall=0, SHALL load Instr<=ImemData, PcPlus4<=PC+4, Valid<=1, PC<=PC+4, remain FETCH (1-cycle latency, one instruction per cycle at zero wait).
REQ-018 In FETCH with ImemReady=1 and Stall=1, SHALL capture ImemData and PC+4 into a one-entry skid buffer, set PC<=PC+4, go HOLD; IF/ID unchanged.
REQ-019 In FETCH with ImemReady=0 and Stall=0, SHALL set Valid<=0 (bubble); PC unchanged.
REQ-020 In HOLD with Stall=0, SHALL move the skid entry into IF/ID with Valid<=1 and go FETCH; in HOLD with Stall=1, SHALL change nothing.
REQ-021 While Stall=1 and no redirect, Instr, PcPlus4 and Valid SHALL hold their values.
REQ-022 BranchTaken=1 SHALL take priority over Stall and ImemReady: PC<=BranchTarget, Valid<=0, skid discarded, any same-cycle ImemData discarded, next state FETCH.
REQ-023 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 without error.

Reset
REQ-024 Reset=1 SHALL asynchronously force PC=RESET_PC, state=FETCH, Valid=0, Instr=0, PcPlus4=0, skid empty, AlignErr=0.
REQ-025 Reset asserted mid-fetch or in HOLD SHALL discard the outstanding response; first request after release SHALL be to RESET_PC.
REQ-026 ImemReq SHALL be 0 while Reset=1.

Configuration
REQ-027 Macro FETCH_ALIGN_CHECK_EN defined: redirect with BranchTarget[1:0]!=0 SHALL set AlignErr (sticky until Reset) and load PC with BranchTarget[1:0] forced to 2'b00.
REQ-028 Macro undefined: AlignErr SHALL be tied 0 and BranchTarget SHALL be loaded unmodified.

Structure
REQ-029 Shared package mips_pkg SHALL hold opcode constants (R-type 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100), the default reset PC constant and the fetch FSM state encoding.
REQ-030 The skid buffer SHALL be a sub-module fetch_skid (one entry: 32-bit instr, 32-bit pc+4, full flag, load/drain/clear).

Verification
REQ-031 Reset release, ImemReady=1 always, Stall=0 -> ImemAddr 0,4,8 on consecutive cycles; Valid=1 from cycle 2; PcPlus4 4,8,12.
REQ-032 ImemData=32'h8C08_0004 at PC 0 -> OpCode=6'b100011 and PcPlus4=4 one cycle later.
REQ-033 Stall=1 for 3 cycles while response at PC 8 returns -> IF/ID holds PC-4 instruction, ImemReq=0 in HOLD, PC-8 instruction appears the cycle after Stall drops, none lost or duplicated.
REQ-034 BranchTaken=1, BranchTarget=32'h0000_0040, simultaneous Stall=1 and ImemReady=1 -> next cycle Valid=0, ImemAddr=32'h40, skid empty.
REQ-035 Reset pulsed in HOLD -> Valid=0, ImemAddr=RESET_PC after release, skid contents never emitted.
REQ-036 With FETCH_ALIGN_CHECK_EN, BranchTarget=32'h0000_0042 -> ImemAddr=32'h40, AlignErr=1 until Reset; without macro, ImemAddr=32'h42, AlignErr=0.
